// File: rtl/graphics_pkg.sv
// Shared types and palette for the graphics compositor and its fright-mode FSM.
package graphics_pkg;

  localparam int COLOR_W = 8;

  // RGB332 palette
  localparam logic [COLOR_W-1:0] RED = 8'hE0;
  localparam logic [COLOR_W-1:0] PNK = 8'hF2;
  localparam logic [COLOR_W-1:0] CYN = 8'h1F;
  localparam logic [COLOR_W-1:0] ORG = 8'hEC;
  localparam logic [COLOR_W-1:0] YLW = 8'hFC;
  localparam logic [COLOR_W-1:0] WHT = 8'hFF;
  localparam logic [COLOR_W-1:0] CRM = 8'hF6;
  localparam logic [COLOR_W-1:0] BLU = 8'h03;
  localparam logic [COLOR_W-1:0] BLK = 8'h00;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FRIGHT = 2'b01,
    FLASH  = 2'b10
  } fright_mode_t;

endpackage

// File: rtl/graphics_fright_fsm.sv
// Frightened/flash mode sequencer; all timing is counted in frame ticks.
module graphics_fright_fsm
  import graphics_pkg::*;
#(
  parameter int FRIGHT_FRAMES = 360,
  parameter int FLASH_FRAMES  = 120,
  parameter int FLASH_PERIOD  = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_tick,
  input  logic         fright_start,
  output fright_mode_t fright_mode,
  output logic         flash_phase
);

  localparam int FR_MAX = (FRIGHT_FRAMES > FLASH_FRAMES) ? FRIGHT_FRAMES : FLASH_FRAMES;
  localparam int FR_W   = (FR_MAX > 1) ? $clog2(FR_MAX) : 1;
  localparam int FL_W   = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  localparam logic [FR_W-1:0] FRIGHT_LAST = FR_W'(FRIGHT_FRAMES - 1);
  localparam logic [FR_W-1:0] FLASH_LAST  = FR_W'(FLASH_FRAMES - 1);
  localparam logic [FL_W-1:0] PERIOD_LAST = FL_W'(FLASH_PERIOD - 1);

  fright_mode_t    state_q, state_d;
  logic [FR_W-1:0] fr_cnt_q, fr_cnt_d;
  logic [FL_W-1:0] flash_cnt_q, flash_cnt_d;
  logic            flash_phase_q, flash_phase_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= NORMAL;
      fr_cnt_q      <= '0;
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fr_cnt_q      <= fr_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  // A restart request outranks any terminal tick arriving in the same cycle.
  always_comb begin
    state_d       = state_q;
    fr_cnt_d      = fr_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;
    if (fright_start) begin
      state_d       = FRIGHT;
      fr_cnt_d      = '0;
      flash_cnt_d   = '0;
      flash_phase_d = 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        FRIGHT: begin
          if (fr_cnt_q == FRIGHT_LAST) begin
            state_d       = FLASH;
            fr_cnt_d      = '0;
            flash_cnt_d   = '0;
            flash_phase_d = 1'b0;
          end else begin
            fr_cnt_d = fr_cnt_q + 1'b1;
          end
        end
        FLASH: begin
          if (flash_cnt_q == PERIOD_LAST) begin
            flash_cnt_d   = '0;
            flash_phase_d = ~flash_phase_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          if (fr_cnt_q == FLASH_LAST) begin
            state_d  = NORMAL;
            fr_cnt_d = '0;
          end else begin
            fr_cnt_d = fr_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fright_mode = state_q;
    flash_phase = flash_phase_q;
  end

endmodule

// File: rtl/graphics_compositor.sv
// Two-stage priority compositor with frame detect, animation phase and ghost recolor.
// Build option GRAPHICS_COMPOSITOR_BG_EN: emit BG_COLOR when no enabled layer is opaque.
module graphics_compositor #(
  parameter int                    NUM_LAYERS    = 6,
  parameter int                    COLOR_W       = 8,
  parameter logic [COLOR_W-1:0]    TRANSPARENT   = 8'h00,
  parameter logic [NUM_LAYERS-1:0] GHOST_MASK    = 6'b001111,
  parameter int                    ANIM_FRAMES   = 8,
  parameter int                    FRIGHT_FRAMES = 360,
  parameter int                    FLASH_FRAMES  = 120,
  parameter int                    FLASH_PERIOD  = 15,
  parameter logic [COLOR_W-1:0]    BG_COLOR      = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    xpos,
  input  logic [9:0]                    ypos,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          fright_start,
  output logic [COLOR_W-1:0]            color,
  output logic                          frame_tick,
  output logic                          anim_phase,
  output logic [1:0]                    fright_mode
);
  import graphics_pkg::*;

  localparam int AN_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [AN_W-1:0] ANIM_LAST = AN_W'(ANIM_FRAMES - 1);

  logic            at_q;
  logic            tick_q;
  logic [AN_W-1:0] anim_cnt_q, anim_cnt_d;
  logic            anim_phase_q, anim_phase_d;

  fright_mode_t mode_w;
  logic         flash_phase_w;

  logic [COLOR_W-1:0] lyr_p1_d [NUM_LAYERS];
  logic [COLOR_W-1:0] lyr_p1_q [NUM_LAYERS];
  logic [COLOR_W-1:0] color_p2_d, color_p2_q;

  function automatic logic [COLOR_W-1:0] recolor(
    input logic [COLOR_W-1:0] c,
    input logic               en,
    input logic               ghost,
    input fright_mode_t       mode,
    input logic               ph
  );
    if (!en || c == TRANSPARENT) return TRANSPARENT;
    if (ghost && mode == FRIGHT) return COLOR_W'(BLU);
    if (ghost && mode == FLASH) return ph ? COLOR_W'(WHT) : COLOR_W'(BLU);
    return c;
  endfunction

  graphics_fright_fsm #(
    .FRIGHT_FRAMES(FRIGHT_FRAMES),
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PERIOD (FLASH_PERIOD)
  ) u_fright_fsm (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (tick_q),
    .fright_start(fright_start),
    .fright_mode (mode_w),
    .flash_phase (flash_phase_w)
  );

  // Frame detect: a held origin position yields a single tick on its first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      at_q         <= 1'b0;
      tick_q       <= 1'b0;
      anim_cnt_q   <= '0;
      anim_phase_q <= 1'b0;
    end else begin
      at_q         <= (xpos == 10'd0) && (ypos == 10'd0);
      tick_q       <= (xpos == 10'd0) && (ypos == 10'd0) && !at_q;
      anim_cnt_q   <= anim_cnt_d;
      anim_phase_q <= anim_phase_d;
    end
  end

  always_comb begin
    anim_cnt_d   = anim_cnt_q;
    anim_phase_d = anim_phase_q;
    if (tick_q) begin
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_d   = '0;
        anim_phase_d = ~anim_phase_q;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: enable gating and ghost recolor, disabled layers collapse to transparent
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      lyr_p1_d[i] = recolor(layer_color[i*COLOR_W +: COLOR_W], layer_en[i],
                            GHOST_MASK[i], mode_w, flash_phase_w);
    end
  end

  // Stage 2: lowest-index opaque layer wins
  always_comb begin
`ifdef GRAPHICS_COMPOSITOR_BG_EN
    color_p2_d = BG_COLOR;
`else
    color_p2_d = TRANSPARENT;
`endif
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (lyr_p1_q[i] != TRANSPARENT) color_p2_d = lyr_p1_q[i];
    end
  end

`ifndef GRAPHICS_COMPOSITOR_BG_EN
  logic unused_bg;
  assign unused_bg = ^BG_COLOR;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) lyr_p1_q[i] <= TRANSPARENT;
      color_p2_q <= TRANSPARENT;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) lyr_p1_q[i] <= lyr_p1_d[i];
      color_p2_q <= color_p2_d;
    end
  end

  assign color       = color_p2_q;
  assign frame_tick  = tick_q;
  assign anim_phase  = anim_phase_q;
  assign fright_mode = mode_w;

endmodule

// File: tb/tb_graphics_compositor.sv
// Self-checking bench for graphics_compositor against a frame-count reference model.
module tb_graphics_compositor;

`ifdef GRAPHICS_COMPOSITOR_BG_EN
  localparam logic [7:0] BG_EXP = 8'h49;
`else
  localparam logic [7:0] BG_EXP = 8'h00;
`endif
  localparam logic [47:0] DIR = {8'h24, 8'hEC, 8'h1F, 8'h00, 8'hF2, 8'hE0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  xpos = 10'd5;
  logic [9:0]  ypos = 10'd7;
  logic [47:0] layer_color = '0;
  logic [5:0]  layer_en = '0;
  logic        fright_start = 1'b0;
  logic [7:0]  color;
  logic        frame_tick;
  logic        anim_phase;
  logic [1:0]  fright_mode;

  int checks = 0;
  int failures = 0;
  int tick_total = 0;
  bit fr_active = 1'b0;
  int fr_k = 0;

  always #5 clk = ~clk;

  graphics_compositor #(.BG_COLOR(8'h49)) dut (
    .clk         (clk),
    .rst         (rst),
    .xpos        (xpos),
    .ypos        (ypos),
    .layer_color (layer_color),
    .layer_en    (layer_en),
    .fright_start(fright_start),
    .color       (color),
    .frame_tick  (frame_tick),
    .anim_phase  (anim_phase),
    .fright_mode (fright_mode)
  );

  // Reference model: mode derived from frames elapsed since the last fright request.
  function automatic logic [1:0] exp_mode();
    if (!fr_active) return 2'b00;
    if (fr_k < 360) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic exp_anim();
    return ((tick_total / 8) % 2) == 1;
  endfunction

  function automatic logic [7:0] model_color(input logic [47:0] lc, input logic [5:0] en);
    logic [1:0] m;
    bit         white;
    logic [7:0] c;
    m = exp_mode();
    white = (m == 2'b10) && (((fr_k - 360) / 15) % 2 == 1);
    for (int i = 0; i < 6; i++) begin
      c = lc[i*8 +: 8];
      if (en[i] && c != 8'h00) begin
        if (i < 4 && m == 2'b01) return 8'h03;
        if (i < 4 && m == 2'b10) return white ? 8'hFF : 8'h03;
        return c;
      end
    end
    return BG_EXP;
  endfunction

  function automatic logic [47:0] rand_layers();
    logic [47:0] v;
    for (int i = 0; i < 6; i++)
      v[i*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
    return v;
  endfunction

  // One frame: origin held for `hold` cycles, then enough cycles for the pipeline to settle.
  task automatic run_frame(input int hold, output int ticks);
    ticks = 0;
    xpos = 10'd0;
    ypos = 10'd0;
    for (int c = 0; c < hold + 4; c++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
      if (c == hold - 1) begin
        xpos = 10'd5;
        ypos = 10'd7;
      end
    end
    tick_total++;
    if (fr_active) begin
      fr_k++;
      if (fr_k >= 480) fr_active = 1'b0;
    end
  endtask

  task automatic pulse_fright();
    fright_start = 1'b1;
    @(negedge clk);
    fright_start = 1'b0;
    fr_active = 1'b1;
    fr_k = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++; if (color !== 8'h00) begin failures++; $display("FAIL reset_color got=%h exp=%h", color, 8'h00); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    checks++; if (anim_phase !== 1'b0) begin failures++; $display("FAIL reset_anim got=%b exp=0", anim_phase); end
    checks++; if (fright_mode !== 2'b00) begin failures++; $display("FAIL reset_mode got=%b exp=00", fright_mode); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick_total = 0;
    fr_active = 1'b0;
  endtask

  task automatic test_priority();
    logic [7:0]  exp_hist [200];
    logic [47:0] lc;
    logic [5:0]  en;
    layer_color = DIR; layer_en = 6'h3F;
    repeat (2) @(negedge clk);
    checks++; if (color !== 8'hE0) begin failures++; $display("FAIL prio_all got=%h exp=%h", color, 8'hE0); end
    layer_en = 6'h3E;
    repeat (2) @(negedge clk);
    checks++; if (color !== 8'hF2) begin failures++; $display("FAIL prio_l0_off got=%h exp=%h", color, 8'hF2); end
    layer_en = 6'b100000;
    repeat (2) @(negedge clk);
    checks++; if (color !== 8'h24) begin failures++; $display("FAIL prio_only5 got=%h exp=%h", color, 8'h24); end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (color !== exp_hist[n-2]) begin
          failures++; $display("FAIL pipe_rand n=%0d got=%h exp=%h", n, color, exp_hist[n-2]);
        end
      end
      lc = rand_layers(); en = 6'($urandom);
      layer_color = lc; layer_en = en;
      exp_hist[n] = model_color(lc, en);
    end
  endtask

  task automatic test_frame_anim();
    int t;
    for (int f = 0; f < 16; f++) begin
      run_frame(4, t);
      checks++; if (t !== 1) begin failures++; $display("FAIL frame_ticks f=%0d got=%0d exp=1", f, t); end
      checks++; if (anim_phase !== exp_anim()) begin failures++; $display("FAIL anim f=%0d got=%b exp=%b", f, anim_phase, exp_anim()); end
    end
  endtask

  task automatic fright_frames(input int nframes);
    int          t;
    logic [47:0] lc;
    logic [5:0]  en;
    for (int f = 0; f < nframes; f++) begin
      case (f % 3)
        0:       begin lc = DIR; en = 6'h3F; end
        1:       begin lc = DIR; en = 6'b110000; end
        default: begin lc = rand_layers(); en = 6'($urandom); end
      endcase
      layer_color = lc; layer_en = en;
      run_frame(1, t);
      checks++; if (t !== 1) begin failures++; $display("FAIL fr_ticks k=%0d got=%0d exp=1", fr_k, t); end
      checks++; if (fright_mode !== exp_mode()) begin failures++; $display("FAIL fr_mode k=%0d got=%b exp=%b", fr_k, fright_mode, exp_mode()); end
      checks++; if (color !== model_color(lc, en)) begin failures++; $display("FAIL fr_color k=%0d got=%h exp=%h", fr_k, color, model_color(lc, en)); end
      checks++; if (anim_phase !== exp_anim()) begin failures++; $display("FAIL fr_anim k=%0d got=%b exp=%b", fr_k, anim_phase, exp_anim()); end
    end
  endtask

  task automatic test_fright();
    pulse_fright();
    checks++; if (fright_mode !== 2'b01) begin failures++; $display("FAIL fr_enter got=%b exp=01", fright_mode); end
    fright_frames(400);
    pulse_fright();
    checks++; if (fright_mode !== 2'b01) begin failures++; $display("FAIL fr_restart got=%b exp=01", fright_mode); end
    fright_frames(485);
  endtask

  task automatic test_reset_mid();
    int t;
    pulse_fright();
    run_frame(1, t);
    while (!exp_anim()) run_frame(1, t);
    layer_color = DIR; layer_en = 6'h3F;
    repeat (3) @(negedge clk);
    checks++; if (color !== 8'h03) begin failures++; $display("FAIL mid_pre got=%h exp=%h", color, 8'h03); end
    checks++; if (anim_phase !== 1'b1) begin failures++; $display("FAIL mid_anim_pre got=%b exp=1", anim_phase); end
    #2 rst = 1'b0;
    #1;
    checks++; if (color !== 8'h00) begin failures++; $display("FAIL mid_color got=%h exp=%h", color, 8'h00); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL mid_tick got=%b exp=0", frame_tick); end
    checks++; if (anim_phase !== 1'b0) begin failures++; $display("FAIL mid_anim got=%b exp=0", anim_phase); end
    checks++; if (fright_mode !== 2'b00) begin failures++; $display("FAIL mid_mode got=%b exp=00", fright_mode); end
    tick_total = 0;
    fr_active = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (color !== 8'h00) begin failures++; $display("FAIL rel_1 got=%h exp=%h", color, 8'h00); end
    @(negedge clk);
    checks++; if (color !== 8'hE0) begin failures++; $display("FAIL rel_2 got=%h exp=%h", color, 8'hE0); end
  endtask

  task automatic test_bg();
    layer_color = '0; layer_en = 6'h3F;
    repeat (2) @(negedge clk);
    checks++; if (color !== BG_EXP) begin failures++; $display("FAIL bg_transp got=%h exp=%h", color, BG_EXP); end
    layer_color = DIR; layer_en = 6'h00;
    repeat (2) @(negedge clk);
    checks++; if (color !== BG_EXP) begin failures++; $display("FAIL bg_disabled got=%h exp=%h", color, BG_EXP); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_priority();
    test_frame_anim();
    test_fright();
    test_reset_mid();
    test_bg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
